// File: rtl/sat_share_ctrl_pkg.sv
// rtl/sat_share_ctrl_pkg.sv - shared types and constants for the saturation-engine share controller
// Contents: FSM state type, engine data width, engine clamp limit.
package sat_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sat_ctrl_state_t;

  localparam int SAT_DW = 8;
  localparam logic [SAT_DW-1:0] SAT_LIMIT = 8'd200;

endpackage

// File: rtl/sat_share_ctrl_if.sv
// rtl/sat_share_ctrl_if.sv - requester and engine handshake bundle for sat_share_ctrl
// Requester side: req_valid, req_data, req_ready, rsp_valid, rsp_data, rsp_err.
// Engine side:    eng_valid, eng_din, eng_ready, eng_dout.
// Modports: slave = controller view, master = requesters plus engine view.
interface sat_share_ctrl_if
  import sat_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = SAT_DW
);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic                rsp_err;
  logic                eng_valid;
  logic [DW-1:0]       eng_din;
  logic                eng_ready;
  logic [DW-1:0]       eng_dout;

  modport slave (
    input  req_valid, req_data, eng_ready, eng_dout,
    output req_ready, rsp_valid, rsp_data, rsp_err, eng_valid, eng_din
  );

  modport master (
    output req_valid, req_data, eng_ready, eng_dout,
    input  req_ready, rsp_valid, rsp_data, rsp_err, eng_valid, eng_din
  );

endinterface

// File: rtl/sat_share_ctrl_arb.sv
// rtl/sat_share_ctrl_arb.sv - combinational round-robin winner select
// Ports: req_valid (in) pending requests, ptr (in) highest-priority index,
//        winner (out) selected index, onehot (out) one-hot of winner, any (out) some request pending.
module sat_rr_arb
  import sat_ctrl_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    winner,
  output logic [N_REQ-1:0] onehot,
  output logic             any
);

  always_comb begin
    int          idx;
    logic [PW-1:0] cand;
    winner = '0;
    onehot = '0;
    any    = 1'b0;
    idx    = 0;
    cand   = '0;
    // Scan ptr, ptr+1, ... wrapping at N_REQ; the first hit wins.
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = PW'(idx);
      if (!any && req_valid[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
    end
    if (any) onehot[winner] = 1'b1;
  end

endmodule

// File: rtl/sat_share_ctrl.sv
// rtl/sat_share_ctrl.sv - round-robin sharing of one saturation engine among N_REQ requesters
// Ports: clk, rst (async active-low), bus (slave modport: requests, responses, engine handshake),
//        busy (state != IDLE), grant_id (current or last winner).
module sat_share_ctrl
  import sat_ctrl_pkg::*;
#(
  parameter int  N_REQ   = 4,
  parameter int  DW      = SAT_DW,
  parameter int  TIMEOUT = 16,
  localparam int PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int TW      = $clog2(TIMEOUT)
) (
  input  logic                  clk,
  input  logic                  rst,
  sat_share_ctrl_if.slave       bus,
  output logic                  busy,
  output logic [PW-1:0]         grant_id
);

  sat_ctrl_state_t  state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    winner;
  logic [PW-1:0]    next_ptr;
  logic [N_REQ-1:0] win_oh;
  logic             any_req;
  logic             seen_low;
  logic [TW-1:0]    timer;
  logic             done_ok;
  logic             abort;

  sat_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req_valid (bus.req_valid),
    .ptr       (ptr),
    .winner    (winner),
    .onehot    (win_oh),
    .any       (any_req)
  );

  // Accept only when the engine is idle-ready; gated by rst so nothing is offered during reset.
  assign bus.req_ready = (rst && state == IDLE && bus.eng_ready) ? win_oh : '0;
  assign bus.eng_valid = (state == ISSUE);
  assign busy          = (state != IDLE);

  // The engine answers only after a low phase on Ready, so a Ready still high from the
  // latch edge is not mistaken for the result.
  assign done_ok  = (state == WAIT) && seen_low && bus.eng_ready;
  assign abort    = (state == ISSUE || state == WAIT) && (timer == TW'(TIMEOUT - 1)) && !done_ok;
  assign next_ptr = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ptr           <= '0;
      grant_id      <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_data  <= '0;
      bus.eng_din   <= '0;
      timer         <= '0;
      seen_low      <= 1'b0;
    end else begin
      bus.rsp_valid <= '0;
      bus.rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req && bus.eng_ready) begin
            bus.eng_din <= bus.req_data[int'(winner)*DW +: DW];
            grant_id    <= winner;
            timer       <= '0;
            seen_low    <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= timer + 1'b1;
          if (bus.eng_ready) state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (!bus.eng_ready) seen_low <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      // Finishing a transaction overrides the per-state updates above.
      if (done_ok || abort) begin
        bus.rsp_valid <= N_REQ'(1) << grant_id;
        bus.rsp_err   <= abort;
        bus.rsp_data  <= done_ok ? bus.eng_dout : '0;
        ptr           <= next_ptr;
        seen_low      <= 1'b0;
        state         <= IDLE;
      end
    end
  end

endmodule
